// File: rtl/ifetch.sv
// Instruction fetch front end: PC, direct-mapped one-word-per-line I-cache,
// miss requests to the memory controller, and 2-bit BHT branch prediction.
`ifndef INST_WID
`define INST_WID 32
`endif
`ifndef ADDR_WID
`define ADDR_WID 32
`endif

module ifetch #(
    parameter int ICACHE_IDX_W = 8,
    parameter int BHT_IDX_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 stall,
    output logic                 inst_done,
    output logic [`INST_WID-1:0] inst,
    output logic [`ADDR_WID-1:0] inst_pc,
    output logic                 inst_pre_j,
    output logic                 mc_en,
    output logic [`ADDR_WID-1:0] mc_addr,
    input  logic                 mc_done,
    input  logic [31:0]          mc_data,
    input  logic                 rollback,
    input  logic [`ADDR_WID-1:0] rollback_pc,
    input  logic                 br_upd,
    input  logic [`ADDR_WID-1:0] br_upd_pc,
    input  logic                 br_upd_jump
);
    localparam int LINES = 1 << ICACHE_IDX_W;
    localparam int BHT_N = 1 << BHT_IDX_W;
    localparam int TAG_W = `ADDR_WID - ICACHE_IDX_W - 2;
    localparam logic [6:0] OPC_JAL = 7'b1101111;
    localparam logic [6:0] OPC_BR  = 7'b1100011;

    typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;
    state_t state, state_n;

    logic [`ADDR_WID-1:0]  pc;
    logic [LINES-1:0]      valid;
    logic [TAG_W-1:0]      tag_ram  [LINES];
    logic [31:0]           data_ram [LINES];
    logic [BHT_N-1:0][1:0] bht;

    logic [ICACHE_IDX_W-1:0] idx, fill_idx;
    logic [BHT_IDX_W-1:0]    bht_idx, upd_idx;
    logic [31:0]             word;
    logic                    hit, pred;
    logic [`ADDR_WID-1:0]    imm_j, imm_b, next_pc;
    logic                    do_issue, do_miss, do_fill;

    assign idx      = pc[ICACHE_IDX_W+1:2];
    assign fill_idx = mc_addr[ICACHE_IDX_W+1:2];
    assign bht_idx  = pc[BHT_IDX_W+1:2];
    assign upd_idx  = br_upd_pc[BHT_IDX_W+1:2];
    assign word     = data_ram[idx];
    assign hit      = valid[idx] && (tag_ram[idx] == pc[`ADDR_WID-1:ICACHE_IDX_W+2]);

    logic unused_upd_bits;
    assign unused_upd_bits = ^{br_upd_pc[`ADDR_WID-1:BHT_IDX_W+2], br_upd_pc[1:0]};

    assign imm_j = {{(`ADDR_WID-20){word[31]}}, word[19:12], word[20], word[30:21], 1'b0};
    assign imm_b = {{(`ADDR_WID-12){word[31]}}, word[7], word[30:25], word[11:8], 1'b0};

    // Prediction reads the BHT register directly, so a same-cycle update is not yet visible.
    always_comb begin
        pred    = 1'b0;
        next_pc = pc + `ADDR_WID'(4);
        if (word[6:0] == OPC_JAL) begin
            pred    = 1'b1;
            next_pc = pc + imm_j;
        end else if (word[6:0] == OPC_BR) begin
            pred = bht[bht_idx][1];
            if (pred) next_pc = pc + imm_b;
        end
    end

    // Memory handshake: mc_en rises with mc_addr and stays high until the cycle
    // mc_done pulses (or a rollback abandons it); mc_done is only meaningful while waiting.
    always_comb begin
        state_n  = state;
        do_issue = 1'b0;
        do_miss  = 1'b0;
        do_fill  = (state == WAIT_MEM) && mc_done;
        if (rollback) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!hit) begin
                        do_miss = 1'b1;
                        state_n = WAIT_MEM;
                    end else if (!stall) begin
                        do_issue = 1'b1;
                    end
                end
                WAIT_MEM: if (mc_done) state_n = IDLE;
                default:  state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)      state <= IDLE;
        else if (rdy) state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= '0;
            valid      <= '0;
            bht        <= {BHT_N{2'b01}};
            inst_done  <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            inst_pre_j <= 1'b0;
            mc_en      <= 1'b0;
            mc_addr    <= '0;
        end else if (rdy) begin
            inst_done <= do_issue;
            if (do_issue) begin
                inst       <= word;
                inst_pc    <= pc;
                inst_pre_j <= pred;
                pc         <= next_pc;
            end
            if (do_miss) begin
                mc_en   <= 1'b1;
                mc_addr <= pc;
            end
            if (do_fill) begin
                valid[fill_idx] <= 1'b1;
                mc_en           <= 1'b0;
            end
            if (rollback) begin
                pc    <= rollback_pc;
                mc_en <= 1'b0;
            end
            if (br_upd) begin
                if (br_upd_jump) begin
                    if (bht[upd_idx] != 2'b11) bht[upd_idx] <= bht[upd_idx] + 2'b01;
                end else begin
                    if (bht[upd_idx] != 2'b00) bht[upd_idx] <= bht[upd_idx] - 2'b01;
                end
            end
        end
    end

    // A word returning alongside a rollback still lands: its address is valid.
    always_ff @(posedge clk) begin
        if (!rst && rdy && do_fill) begin
            data_ram[fill_idx] <= mc_data;
            tag_ram[fill_idx]  <= mc_addr[`ADDR_WID-1:ICACHE_IDX_W+2];
        end
    end
endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: memory responder, program/BHT reference model with an
// expected-issue queue, directed scenarios followed by a randomized run.
module tb_ifetch;
    logic        clk = 1'b0;
    logic        rst, rdy, stall;
    logic        inst_done, inst_pre_j, mc_en, mc_done;
    logic [31:0] inst, inst_pc, mc_addr, mc_data;
    logic        rollback, br_upd, br_upd_jump;
    logic [31:0] rollback_pc, br_upd_pc;

    ifetch dut (
        .clk(clk), .rst(rst), .rdy(rdy), .stall(stall),
        .inst_done(inst_done), .inst(inst), .inst_pc(inst_pc), .inst_pre_j(inst_pre_j),
        .mc_en(mc_en), .mc_addr(mc_addr), .mc_done(mc_done), .mc_data(mc_data),
        .rollback(rollback), .rollback_pc(rollback_pc),
        .br_upd(br_upd), .br_upd_pc(br_upd_pc), .br_upd_jump(br_upd_jump)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Program image: raw words plus a kind/offset description used by the model.
    logic [31:0] mem    [logic [31:0]];
    int          kind_t [logic [31:0]];   // 0 other, 1 jal, 2 branch
    logic [31:0] off_t  [logic [31:0]];

    logic [64:0] exp_q[$];                // {pred, pc, inst}
    int          model_bht [256];
    logic [31:0] model_pc;
    bit          sb_on, auto_resp, issued;
    int          cnt, lat, n_issued;
    logic [98:0] snap;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0000_0013;
    endfunction

    function automatic logic [31:0] enc_j(logic [31:0] o);
        return {o[20], o[10:1], o[11], o[19:12], 5'd0, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_b(logic [31:0] o);
        return {o[12], o[10:5], 5'd0, 5'd0, 3'd0, o[4:1], o[11], 7'b1100011};
    endfunction

    function automatic logic [98:0] outs();
        return {inst_done, inst, inst_pc, inst_pre_j, mc_en, mc_addr};
    endfunction

    task automatic put(logic [31:0] a, int k, logic [31:0] off, logic [31:0] raw);
        kind_t[a] = k;
        off_t[a]  = off;
        mem[a]    = (k == 1) ? enc_j(off) : (k == 2) ? enc_b(off) : raw;
    endtask

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) model_bht[i] = 1;
        model_pc = 32'h0;
        exp_q.delete();
    endtask

    task automatic model_step();
        logic [31:0] p, nx;
        bit          pr;
        int          k;
        p  = model_pc;
        k  = kind_t.exists(p) ? kind_t[p] : 0;
        pr = 1'b0;
        nx = p + 32'd4;
        if (k == 1) begin
            pr = 1'b1;
            nx = p + off_t[p];
        end else if (k == 2) begin
            pr = (model_bht[p[9:2]] >= 2);
            if (pr) nx = p + off_t[p];
        end
        exp_q.push_back({pr, p, mem_word(p)});
        model_pc = nx;
    endtask

    task automatic model_upd(logic [31:0] a, bit j);
        if (j && model_bht[a[9:2]] < 3) model_bht[a[9:2]]++;
        else if (!j && model_bht[a[9:2]] > 0) model_bht[a[9:2]]--;
    endtask

    // One clock: memory responder decides mc_done for the coming edge, then
    // outputs of that edge are sampled at the following negedge.
    task automatic tick();
        bit          r;
        logic [64:0] e;
        r = rdy && !rst;
        if (auto_resp && r && mc_en) begin
            if (cnt >= lat) begin
                mc_done = 1'b1;
                mc_data = mem_word(mc_addr);
                cnt     = 0;
                lat     = $urandom_range(0, 3);
            end else begin
                cnt++;
            end
        end else if (!mc_en) begin
            cnt = 0;
        end
        @(negedge clk);
        mc_done = 1'b0;
        issued  = 1'b0;
        if (r && inst_done) begin
            issued = 1'b1;
            n_issued++;
            if (sb_on) begin
                model_step();
                e = exp_q.pop_front();
                chk("issue", 128'({inst_pre_j, inst_pc, inst}), 128'(e));
            end
        end
    endtask

    task automatic do_rollback(logic [31:0] a);
        rollback    = 1'b1;
        rollback_pc = a;
        model_pc    = a;
        exp_q.delete();
        tick();
        rollback = 1'b0;
    endtask

    task automatic wait_issue(string tag, logic [31:0] a, int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (issued && inst_pc == a) got = 1'b1;
        end
        chk(tag, 128'(got), 128'd1);
    endtask

    task automatic expect_next(string tag, logic [31:0] a, int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (issued) got = 1'b1;
        end
        chk(tag, 128'(got ? inst_pc : 32'hDEAD_BEEF), 128'(a));
    endtask

    task automatic upd_stalled(logic [31:0] a, bit j);
        stall       = 1'b1;
        br_upd      = 1'b1;
        br_upd_pc   = a;
        br_upd_jump = j;
        model_upd(a, j);
        tick();
        br_upd = 1'b0;
        stall  = 1'b0;
    endtask

    initial begin
        logic [6:0]  opcs [4];
        logic [31:0] a, off;
        int          k;

        rst = 1'b1; rdy = 1'b1; stall = 1'b0;
        mc_done = 1'b0; mc_data = '0;
        rollback = 1'b0; rollback_pc = '0;
        br_upd = 1'b0; br_upd_pc = '0; br_upd_jump = 1'b0;
        sb_on = 1'b0; auto_resp = 1'b0; cnt = 0; lat = 1; n_issued = 0;
        model_reset();

        put(32'h0,  0, 32'h0, 32'h0000_0013);
        put(32'h4,  0, 32'h0, 32'h0000_0013);
        put(32'h8,  1, 32'hFFFF_FFF8, 32'h0);
        put(32'h10, 2, 32'd16, 32'h0);
        put(32'h40, 0, 32'h0, 32'h0010_0093);
        opcs[0] = 7'b0010011; opcs[1] = 7'b0110011; opcs[2] = 7'b1100111; opcs[3] = 7'b0000011;
        for (int i = 0; i < 64; i++) begin
            a   = 32'h400 + 32'(4 * i);
            k   = $urandom_range(0, 9);
            off = 4 * $urandom_range(0, 16) - 32;
            if (k <= 2)      put(a, 2, off, 32'h0);
            else if (k == 3) put(a, 1, off, 32'h0);
            else             put(a, 0, 32'h0, {25'($urandom()), opcs[$urandom_range(0, 3)]});
        end

        // Cold start
        repeat (2) tick();
        chk("reset_outputs", 128'(outs()), 128'd0);
        rst = 1'b0;
        tick();
        chk("cold_mc_en", 128'(mc_en), 128'd1);
        chk("cold_mc_addr", 128'(mc_addr), 128'd0);
        mc_done = 1'b1;
        mc_data = 32'h0000_0013;
        tick();
        chk("cold_fill_mc_en", 128'(mc_en), 128'd0);
        chk("cold_no_early_issue", 128'(inst_done), 128'd0);
        tick();
        chk("cold_issue", 128'({inst_done, inst, inst_pc, inst_pre_j}), 128'({1'b1, 32'h13, 32'h0, 1'b0}));
        tick();
        chk("cold_next_req", 128'({mc_en, mc_addr}), 128'({1'b1, 32'h4}));

        // JAL loop 0x0 -> 0x4 -> 0x8 -> 0x0
        model_pc  = 32'h4;
        sb_on     = 1'b1;
        auto_resp = 1'b1;
        repeat (30) tick();
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("jal_loop_issue", 128'({inst_done, mc_en}), 128'({1'b1, 1'b0}));
            chk("jal_loop_prej", 128'(inst_pre_j), 128'(inst_pc == 32'h8));
        end

        // BHT training on beq at 0x10
        do_rollback(32'h10);
        wait_issue("bht_first_fetch", 32'h10, 40);
        chk("bht_init_prej", 128'(inst_pre_j), 128'd0);
        expect_next("bht_init_next", 32'h14, 40);
        upd_stalled(32'h10, 1'b1);
        do_rollback(32'h10);
        wait_issue("bht_taken_fetch", 32'h10, 40);
        chk("bht_taken_prej", 128'(inst_pre_j), 128'd1);
        expect_next("bht_taken_next", 32'h20, 40);
        upd_stalled(32'h10, 1'b0);
        upd_stalled(32'h10, 1'b0);
        do_rollback(32'h10);
        wait_issue("bht_cold_fetch", 32'h10, 40);
        chk("bht_cold_prej", 128'(inst_pre_j), 128'd0);
        expect_next("bht_cold_next", 32'h14, 40);

        // Stall with hits available
        do_rollback(32'h0);
        repeat (6) tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_quiet", 128'(inst_done), 128'd0);
        end
        stall = 1'b0;
        tick();
        chk("stall_release", 128'(inst_done), 128'd1);

        // Rollback while waiting on 0x40
        auto_resp = 1'b0;
        do_rollback(32'h40);
        tick();
        chk("rb_req_40", 128'({mc_en, mc_addr}), 128'({1'b1, 32'h40}));
        rollback = 1'b1; rollback_pc = 32'h100; model_pc = 32'h100;
        tick();
        rollback = 1'b0;
        chk("rb_drop", 128'({mc_en, inst_done}), 128'd0);
        tick();
        chk("rb_req_100", 128'({mc_en, mc_addr}), 128'({1'b1, 32'h100}));
        auto_resp = 1'b1;
        wait_issue("rb_issue_100", 32'h100, 40);

        // mc_done coinciding with rollback still fills 0x40
        auto_resp = 1'b0;
        do_rollback(32'h40);
        tick();
        chk("rbfill_req_40", 128'({mc_en, mc_addr}), 128'({1'b1, 32'h40}));
        rollback = 1'b1; rollback_pc = 32'h200; model_pc = 32'h200;
        mc_done = 1'b1; mc_data = mem_word(32'h40);
        tick();
        rollback = 1'b0;
        auto_resp = 1'b1;
        wait_issue("rbfill_issue_200", 32'h200, 40);
        do_rollback(32'h40);
        tick();
        chk("rbfill_hit_40", 128'({mc_en, inst_done, inst_pc}), 128'({1'b0, 1'b1, 32'h40}));

        // rdy freeze mid-stream
        do_rollback(32'h0);
        repeat (6) tick();
        snap = outs();
        rdy  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rdy_freeze", 128'(outs()), 128'(snap));
        end
        rdy = 1'b1;
        tick();
        chk("rdy_resume", 128'(inst_done), 128'd1);
        repeat (6) tick();

        // Reset during WAIT_MEM
        auto_resp = 1'b0;
        do_rollback(32'h500);
        tick();
        chk("rst_pre_req", 128'({mc_en, mc_addr}), 128'({1'b1, 32'h500}));
        rst = 1'b1;
        tick();
        chk("rst_outputs", 128'(outs()), 128'd0);
        model_reset();
        rst = 1'b0;
        tick();
        chk("rst_line_invalid", 128'({mc_en, mc_addr}), 128'({1'b1, 32'h0}));
        auto_resp = 1'b1;
        wait_issue("rst_refetch_0", 32'h0, 40);

        // Randomized run over the generated program
        do_rollback(32'h400);
        n_issued = 0;
        for (int i = 0; i < 1500; i++) begin
            rdy   = ($urandom_range(0, 9) != 0);
            stall = ($urandom_range(0, 3) == 0);
            if (rdy && stall && $urandom_range(0, 1) == 1) begin
                br_upd      = 1'b1;
                br_upd_pc   = 32'h400 + 32'(4 * $urandom_range(0, 63));
                br_upd_jump = ($urandom_range(0, 1) == 1);
                model_upd(br_upd_pc, br_upd_jump);
            end
            if (rdy && $urandom_range(0, 39) == 0) begin
                rollback    = 1'b1;
                rollback_pc = 32'h400 + 32'(4 * $urandom_range(0, 63));
                model_pc    = rollback_pc;
                exp_q.delete();
            end
            tick();
            br_upd   = 1'b0;
            rollback = 1'b0;
        end
        rdy   = 1'b1;
        stall = 1'b0;
        repeat (10) tick();
        chk("random_progress", 128'(n_issued > 200), 128'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ifetch.md
Name: ifetch

Overview:
- Instruction fetch front end of the out-of-order RV32I core.
- Owns the PC and a direct-mapped instruction cache, and issues a memory-controller request on a cache miss.
- Predicts control flow with a 2-bit BHT.
- Delivers one instruction per cycle to the decode/issue stage over the inst_done/inst/inst_pc/inst_pre_j interface.
- Redirected by ROB rollback; trains the BHT from ROB branch commits.

Parameters:
- ICACHE_IDX_W, 8, log2 of I-cache line count; one 32-bit word per line.
- BHT_IDX_W, 8, log2 of BHT entry count.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rdy  in  1  global ready; low freezes all state.
- stall  in  1  downstream (RS/LSB/ROB) cannot accept an instruction next cycle.
- inst_done  out  1  one-cycle valid pulse to decoder.
- inst  out  `INST_WID  instruction word.
- inst_pc  out  `ADDR_WID  PC of inst.
- inst_pre_j  out  1  predicted taken.
- mc_en  out  1  memory request active, held until mc_done.
- mc_addr  out  `ADDR_WID  word-aligned fetch address.
- mc_done  in  1  memory word valid (one-cycle pulse).
- mc_data  in  32  fetched word.
- rollback  in  1  mispredict/flush.
- rollback_pc  in  `ADDR_WID  redirect target.
- br_upd  in  1  ROB committed a B-type instruction.
- br_upd_pc  in  `ADDR_WID  PC of the committed branch.
- br_upd_jump  in  1  actual branch outcome.

Behaviour:
- Reset (rst=1 at a posedge, overrides everything):
  - pc=0, state=IDLE.
  - All cache valid bits=0; all BHT counters=2'b01.
  - inst_done=0, inst=0, inst_pc=0, inst_pre_j=0, mc_en=0, mc_addr=0.
- rdy=0: no register changes; outputs hold their values.
- Cache addressing:
  - idx=pc[ICACHE_IDX_W+1:2], tag=pc[31:ICACHE_IDX_W+2].
  - hit = valid[idx] && tag matches.
- State IDLE:
  - Default each cycle: inst_done<=0.
  - Hit && !stall && !rollback:
    - inst_done<=1, inst<=data[idx], inst_pc<=pc, inst_pre_j<=pred.
    - pc<=next_pc.
    - Hits issue back-to-back, one instruction per cycle.
  - Miss && !rollback: mc_en<=1, mc_addr<=pc, state<=WAIT_MEM. Stall does not block miss handling.
  - Hit && stall: hold pc; nothing issued.
- State WAIT_MEM:
  - mc_done=1:
    - data[mc_addr idx]<=mc_data, tag written, valid<=1.
    - mc_en<=0, state<=IDLE.
    - The instruction issues from the next hit cycle: 2 cycles after mc_done at the earliest.
  - inst_done stays 0.
- Prediction (combinational on data[idx]):
  - opcode 1101111 (JAL): pred=1, next_pc=pc+J-imm.
  - opcode 1100011 (B): pred=BHT[pc[BHT_IDX_W+1:2]][1]; next_pc=pred ? pc+B-imm : pc+4.
  - All others, including JALR: pred=0, next_pc=pc+4.
  - Immediates are sign-extended to 32 bits; adds wrap mod 2^32.
- Rollback (has priority over issue and fill-state logic):
  - pc<=rollback_pc, inst_done<=0, mc_en<=0, state<=IDLE.
  - If mc_done coincides with rollback, the returned word is still written to the cache; the address is valid.
  - Dropping mc_en abandons the request; the memory controller must not assert mc_done afterwards.
- BHT update on br_upd:
  - Counter at br_upd_pc index increments (saturate at 3) if br_upd_jump, else decrements (saturate at 0).
  - A same-cycle lookup at that index sees the pre-update value.
  - The update occurs regardless of rollback or stall.
- mc_addr changes only when mc_en rises.

Test Plan:
- Cold start:
  - Stimulus: reset, then mc_done with mc_data=0x00000013 at addr 0.
  - Required: mc_en=1 with mc_addr=0x0; after the fill, inst_done pulse with inst=0x00000013, inst_pc=0x0, pre_j=0; next request has mc_addr=0x4.
- JAL loop:
  - Stimulus: 0x0/0x4 NOPs, 0x8=0xFF9FF06F (jal x0,-8), all filled.
  - Required: steady state issues pc 0x0,0x4,0x8,0x0... on consecutive cycles; pre_j=1 only at 0x8; mc_en stays 0.
- BHT training:
  - Stimulus: 0x10=0x00000863 (beq x0,x0,+16).
  - Required:
    - Initially pre_j=0, next pc 0x14.
    - After one br_upd(0x10, jump=1) the counter is 2; next fetch of 0x10 gives pre_j=1, next pc 0x20.
    - Two further not-taken updates bring the counter to 0 → pre_j=0.
- Stall:
  - Stimulus: stall=1 for 3 cycles with hits available.
  - Required: no inst_done, pc held; first cycle after release issues the held pc with no skip or duplicate.
- Rollback mid-miss:
  - Stimulus: in WAIT_MEM for 0x40, rollback with rollback_pc=0x100.
  - Required: mc_en=0 next cycle, state IDLE; next request mc_addr=0x100; no inst_done for 0x40.
  - Variant: mc_done in the same cycle still fills 0x40 (later fetch of 0x40 hits).
- rdy/reset:
  - Stimulus: rdy=0 for 5 cycles mid-stream.
  - Required: all outputs frozen, resume identical.
  - Stimulus: rst asserted during WAIT_MEM.
  - Required: mc_en=0, pc=0, previously valid lines now miss.
